// File: rtl/ising_ctrl_pkg.sv
// Shared types, default widths and the widened field+noise sum for the
// Ising sweep controller.
package ising_ctrl_pkg;

    localparam int DEF_N_SPINS = 64;
    localparam int DEF_IDX_W   = 6;
    localparam int DEF_FIELD_W = 16;
    localparam int DEF_SWEEP_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        UPDATE,
        DONE
    } state_t;

    // Operands arrive sign-extended to 32 bits; one extra bit of headroom
    // means the sum of two full-scale samples can never wrap.
    function automatic logic signed [32:0] widened_sum(input logic signed [31:0] a,
                                                       input logic signed [31:0] b);
        return 33'(a) + 33'(b);
    endfunction

endpackage

// File: rtl/ising_spin_decide.sv
// Sign decision for one spin: local field plus noise, registered together
// with a flag saying whether the decision differs from the current spin.
module ising_spin_decide
    import ising_ctrl_pkg::*;
#(
    parameter int FIELD_W = DEF_FIELD_W
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               capture,
    input  logic [FIELD_W-1:0] fld_data,
    input  logic [FIELD_W-1:0] rnd_data,
    input  logic               old_bit,
    output logic               new_spin,
    output logic               flip
);

    logic decision;
    logic new_spin_reg;
    logic flip_reg;

    // A zero sum counts as +1.
    assign decision = (widened_sum(32'(signed'(fld_data)), 32'(signed'(rnd_data))) >= 33'sd0);

    // Hold the decision and the flip flag until the controller writes them back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_spin_reg <= 1'b0;
            flip_reg     <= 1'b0;
        end else if (capture) begin
            new_spin_reg <= decision;
            flip_reg     <= (decision != old_bit);
        end
    end

    assign new_spin = new_spin_reg;
    assign flip     = flip_reg;

endmodule

// File: rtl/ising_sweep_ctrl.sv
// Sweep sequencer for the Recurrent Ising Sampler: owns the spin vector,
// requests a local field per spin, adds noise and writes back the sign.
module ising_sweep_ctrl
    import ising_ctrl_pkg::*;
#(
    parameter int N_SPINS = DEF_N_SPINS,
    parameter int IDX_W   = DEF_IDX_W,
    parameter int FIELD_W = DEF_FIELD_W,
    parameter int SWEEP_W = DEF_SWEEP_W
)
(
    input  logic               s00_axi_aclk,
    input  logic               s00_axi_aresetn,
    input  logic               cfg_start,
    input  logic [SWEEP_W-1:0] cfg_sweeps,
    input  logic               cfg_abort,
    input  logic               spin_init_load,
    input  logic [N_SPINS-1:0] spin_init,
    output logic               row_req_valid,
    input  logic               row_req_ready,
    output logic [IDX_W-1:0]   row_req_idx,
    input  logic               fld_valid,
    input  logic [FIELD_W-1:0] fld_data,
    output logic               fld_ready,
    input  logic [FIELD_W-1:0] rnd_data,
    output logic               rnd_ack,
    output logic [N_SPINS-1:0] spin_vec,
    output logic               busy,
    output logic               done,
    output logic [SWEEP_W-1:0] sweep_cnt,
    output logic [31:0]        flip_cnt
);

    state_t             state_reg;
    state_t             state_next;
    logic [IDX_W-1:0]   idx_reg;
    logic [SWEEP_W-1:0] sweeps_reg;
    logic [SWEEP_W-1:0] sweep_cnt_reg;
    logic [31:0]        flip_cnt_reg;
    logic [N_SPINS-1:0] spin_reg;

    logic               last_idx;
    logic [SWEEP_W-1:0] sweep_inc;
    logic               capture;
    logic               new_spin;
    logic               flip;

    assign last_idx  = (idx_reg == IDX_W'(N_SPINS - 1));
    assign sweep_inc = sweep_cnt_reg + SWEEP_W'(1);
    assign capture   = (state_reg == WAIT) && fld_valid && !cfg_abort;

    ising_spin_decide #(
        .FIELD_W (FIELD_W)
    ) u_decide (
        .clk      (s00_axi_aclk),
        .rst_n    (s00_axi_aresetn),
        .capture  (capture),
        .fld_data (fld_data),
        .rnd_data (rnd_data),
        .old_bit  (spin_reg[idx_reg]),
        .new_spin (new_spin),
        .flip     (flip)
    );

    // State register.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state selection; abort wins over every handshake while busy.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cfg_start) begin
                    state_next = (cfg_sweeps != '0) ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (cfg_abort)          state_next = IDLE;
                else if (row_req_ready) state_next = WAIT;
            end
            WAIT: begin
                if (cfg_abort)      state_next = IDLE;
                else if (fld_valid) state_next = UPDATE;
            end
            UPDATE: begin
                if (cfg_abort)                             state_next = IDLE;
                else if (last_idx && sweep_inc == sweeps_reg) state_next = DONE;
                else                                       state_next = ISSUE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Index, sweep and flip bookkeeping; an UPDATE in the abort cycle still lands.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            idx_reg       <= '0;
            sweeps_reg    <= '0;
            sweep_cnt_reg <= '0;
            flip_cnt_reg  <= '0;
        end else if (state_reg == IDLE && cfg_start) begin
            idx_reg       <= '0;
            sweeps_reg    <= cfg_sweeps;
            sweep_cnt_reg <= '0;
            flip_cnt_reg  <= '0;
        end else if (state_reg == UPDATE) begin
            if (flip) begin
                flip_cnt_reg <= flip_cnt_reg + 32'd1;
            end
            if (last_idx) begin
                idx_reg       <= '0;
                sweep_cnt_reg <= sweep_inc;
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

    // Spin vector: host load only while idle, otherwise one write per UPDATE.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            spin_reg <= '0;
        end else if (state_reg == IDLE && spin_init_load) begin
            spin_reg <= spin_init;
        end else if (state_reg == UPDATE) begin
            spin_reg[idx_reg] <= new_spin;
        end
    end

    // The request is withdrawn in the same cycle an abort arrives.
    assign row_req_valid = (state_reg == ISSUE) && !cfg_abort;
    assign row_req_idx   = idx_reg;
    assign fld_ready     = (state_reg == WAIT);
    assign rnd_ack       = (state_reg == UPDATE);
    assign busy          = (state_reg == ISSUE) || (state_reg == WAIT) || (state_reg == UPDATE);
    assign done          = (state_reg == DONE);
    assign spin_vec      = spin_reg;
    assign sweep_cnt     = sweep_cnt_reg;
    assign flip_cnt      = flip_cnt_reg;

endmodule

// File: tb/tb_ising_sweep_ctrl.sv
// Scoreboard bench for ising_sweep_ctrl with a 4-spin instance.
module tb_ising_sweep_ctrl;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int FW = 16;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [SW-1:0] cfg_sweeps = '0;
    logic          cfg_abort = 1'b0;
    logic          spin_init_load = 1'b0;
    logic [N-1:0]  spin_init = '0;
    logic          row_req_valid;
    logic          row_req_ready = 1'b0;
    logic [IW-1:0] row_req_idx;
    logic          fld_valid = 1'b0;
    logic [FW-1:0] fld_data = '0;
    logic          fld_ready;
    logic [FW-1:0] rnd_data = '0;
    logic          rnd_ack;
    logic [N-1:0]  spin_vec;
    logic          busy;
    logic          done;
    logic [SW-1:0] sweep_cnt;
    logic [31:0]   flip_cnt;

    ising_sweep_ctrl #(
        .N_SPINS (N),
        .IDX_W   (IW),
        .FIELD_W (FW),
        .SWEEP_W (SW)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .cfg_start       (cfg_start),
        .cfg_sweeps      (cfg_sweeps),
        .cfg_abort       (cfg_abort),
        .spin_init_load  (spin_init_load),
        .spin_init       (spin_init),
        .row_req_valid   (row_req_valid),
        .row_req_ready   (row_req_ready),
        .row_req_idx     (row_req_idx),
        .fld_valid       (fld_valid),
        .fld_data        (fld_data),
        .fld_ready       (fld_ready),
        .rnd_data        (rnd_data),
        .rnd_ack         (rnd_ack),
        .spin_vec        (spin_vec),
        .busy            (busy),
        .done            (done),
        .sweep_cnt       (sweep_cnt),
        .flip_cnt        (flip_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] f;
        logic [FW-1:0] r;
    } resp_t;

    typedef struct {
        int           sweeps;
        int           flips;
        logic [N-1:0] spins;
    } done_t;

    int    vectors = 0;
    int    miscompares = 0;
    int    exp_idx_q[$];
    resp_t resp_q[$];
    done_t done_q[$];
    int    done_count = 0;
    int    ack_count = 0;
    int    busy_seen = 0;
    int    ready_delay = 0;
    int    valid_delay = 0;
    int    rq_wait = 0;
    int    fv_wait = 0;
    logic signed [FW-1:0] fld_tab [0:11];
    logic signed [FW-1:0] rnd_tab [0:11];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, what);
    endtask

    // MAC engine / noise model: configurable ready and valid delays.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (row_req_valid) begin
                if (rq_wait < ready_delay) begin
                    row_req_ready = 1'b0;
                    rq_wait++;
                end else begin
                    row_req_ready = 1'b1;
                end
            end else begin
                row_req_ready = 1'b0;
                rq_wait = 0;
            end
            if (fld_ready) begin
                if (fv_wait < valid_delay) begin
                    fld_valid = 1'b0;
                    fv_wait++;
                end else if (!fld_valid && resp_q.size() > 0) begin
                    r = resp_q.pop_front();
                    fld_data  = r.f;
                    rnd_data  = r.r;
                    fld_valid = 1'b1;
                end
            end else begin
                fld_valid = 1'b0;
                fv_wait = 0;
            end
        end
    end

    // Monitor: request handshakes, done records and backpressure stability.
    initial begin
        logic          pv;
        logic          pr;
        logic [IW-1:0] pi;
        done_t         d;
        pv = 1'b0;
        pr = 1'b0;
        pi = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                pv = 1'b0;
                continue;
            end
            if (pv && !pr && !cfg_abort) begin
                chk("req_valid_hold", int'(row_req_valid), 1);
                chk("req_idx_hold", int'(row_req_idx), int'(pi));
            end
            if (row_req_valid && row_req_ready) begin
                if (exp_idx_q.size() == 0) fail_now("req_idx", "request with empty scoreboard");
                else chk("req_idx", int'(row_req_idx), exp_idx_q.pop_front());
            end
            if (rnd_ack) ack_count++;
            if (busy) busy_seen++;
            if (done) begin
                done_count++;
                if (done_q.size() == 0) begin
                    fail_now("done", "done pulse with empty scoreboard");
                end else begin
                    d = done_q.pop_front();
                    chk("done_sweep_cnt", int'(sweep_cnt), d.sweeps);
                    chk("done_flip_cnt", int'(flip_cnt), d.flips);
                    chk("done_spin_vec", int'(spin_vec), int'(d.spins));
                    chk("done_busy", int'(busy), 0);
                end
            end
            pv = row_req_valid;
            pr = row_req_ready;
            pi = row_req_idx;
        end
    end

    // One full run: scoreboard fill, start pulse, bounded wait for done.
    task automatic run_test(input string name, input logic load, input logic [N-1:0] init,
                            input int sweeps, input int rdly, input int vdly,
                            input logic [N-1:0] exp_spins, input int exp_flips, input int exp_lat);
        int   lat;
        int   acks0;
        logic got;
        ready_delay = rdly;
        valid_delay = vdly;
        for (int v = 0; v < sweeps * N; v++) begin
            exp_idx_q.push_back(v % N);
            resp_q.push_back('{fld_tab[v], rnd_tab[v]});
        end
        done_q.push_back('{sweeps, exp_flips, exp_spins});
        acks0 = ack_count;
        @(negedge clk);
        spin_init      = init;
        spin_init_load = load;
        cfg_sweeps     = 16'(sweeps);
        cfg_start      = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 2000) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                cfg_start      = 1'b0;
                spin_init_load = 1'b0;
            end
            #3;
            got = done;
        end
        if (!got) fail_now({name, "_done"}, "timeout waiting for done");
        else if (exp_lat >= 0) chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_rnd_acks"}, ack_count - acks0, sweeps * N);
        @(negedge clk);
        #3;
        chk({name, "_done_pulse_width"}, int'(done), 0);
    endtask

    initial begin
        int   dc0;
        int   bs0;
        int   n;
        logic hit;

        // Reset state.
        repeat (3) @(negedge clk);
        #3;
        chk("reset_busy", int'(busy), 0);
        chk("reset_spin_vec", int'(spin_vec), 0);
        rst_n = 1'b1;
        @(negedge clk);
        #3;
        chk("idle_outputs", int'({row_req_valid, fld_ready, rnd_ack, busy, done}), 0);
        chk("idle_counters", int'(sweep_cnt) + int'(flip_cnt), 0);

        // Single sweep, all fields positive.
        for (int v = 0; v < 12; v++) begin fld_tab[v] = 16'sd5; rnd_tab[v] = 16'sd0; end
        run_test("basic", 1'b1, 4'b0000, 1, 0, 0, 4'b1111, 4, 13);

        // Sum boundaries: zero, most negative, most positive.
        fld_tab[0] = -16'sd3;    rnd_tab[0] = 16'sd3;
        fld_tab[1] = 16'sh8000;  rnd_tab[1] = 16'sh8000;
        fld_tab[2] = 16'sh7FFF;  rnd_tab[2] = 16'sh7FFF;
        fld_tab[3] = -16'sd1;    rnd_tab[3] = 16'sd0;
        run_test("boundary", 1'b1, 4'b0010, 1, 0, 0, 4'b0101, 3, 13);

        // Backpressure on both channels.
        fld_tab[0] = -16'sd1; fld_tab[1] = 16'sd2; fld_tab[2] = -16'sd4; fld_tab[3] = 16'sd8;
        for (int v = 0; v < 4; v++) rnd_tab[v] = 16'sd0;
        run_test("backpressure", 1'b1, 4'b1111, 1, 5, 7, 4'b1010, 2, -1);

        // Three sweeps, field sign alternating per visit and per sweep.
        for (int v = 0; v < 12; v++) begin
            fld_tab[v] = (((v + v / 4) % 2) == 0) ? 16'sd7 : -16'sd7;
            rnd_tab[v] = 16'sd0;
        end
        run_test("three_sweeps", 1'b1, 4'b0000, 3, 0, 0, 4'b0101, 10, 37);

        // Zero sweeps: immediate done, counters cleared, never busy.
        bs0 = busy_seen;
        run_test("zero_sweeps", 1'b0, 4'b0000, 0, 0, 0, 4'b0101, 0, 1);
        chk("zero_sweeps_busy_cycles", busy_seen - bs0, 0);

        // Abort while waiting for the field of spin 2.
        for (int v = 0; v < 12; v++) begin fld_tab[v] = 16'sd5; rnd_tab[v] = 16'sd0; end
        ready_delay = 0;
        valid_delay = 2;
        exp_idx_q.push_back(0); exp_idx_q.push_back(1); exp_idx_q.push_back(2);
        resp_q.push_back('{fld_tab[0], rnd_tab[0]});
        resp_q.push_back('{fld_tab[1], rnd_tab[1]});
        dc0 = done_count;
        @(negedge clk);
        spin_init = 4'b0000; spin_init_load = 1'b1; cfg_sweeps = 16'd1; cfg_start = 1'b1;
        @(negedge clk);
        spin_init_load = 1'b0; cfg_start = 1'b0;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
            #3;
            hit = fld_ready && (row_req_idx == 2'd2);
            if (!hit) begin @(negedge clk); n++; end
        end
        if (!hit) fail_now("abort_reach_wait", "timeout waiting for WAIT of spin 2");
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        #3;
        chk("abort_busy", int'(busy), 0);
        chk("abort_spin_vec", int'(spin_vec), 3);
        chk("abort_flip_cnt", int'(flip_cnt), 2);
        chk("abort_sweep_cnt", int'(sweep_cnt), 0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", done_count - dc0, 0);
        chk("abort_scoreboard_drained", exp_idx_q.size(), 0);

        // Normal run after the abort, starting from the partly updated spins.
        for (int v = 0; v < 4; v++) fld_tab[v] = -16'sd5;
        run_test("after_abort", 1'b0, 4'b0000, 1, 0, 0, 4'b0000, 2, 13);

        // Asynchronous reset while waiting for a field.
        for (int v = 0; v < 12; v++) fld_tab[v] = 16'sd5;
        ready_delay = 0;
        valid_delay = 20;
        exp_idx_q.push_back(0);
        dc0 = done_count;
        @(negedge clk);
        spin_init = 4'b1010; spin_init_load = 1'b1; cfg_sweeps = 16'd2; cfg_start = 1'b1;
        @(negedge clk);
        spin_init_load = 1'b0; cfg_start = 1'b0;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
            #3;
            hit = fld_ready;
            if (!hit) begin @(negedge clk); n++; end
        end
        if (!hit) fail_now("reset_reach_wait", "timeout waiting for WAIT");
        chk("pre_reset_spin_vec", int'(spin_vec), 10);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_spin_vec", int'(spin_vec), 0);
        chk("async_reset_flags", int'({row_req_valid, fld_ready, rnd_ack, busy, done}), 0);
        chk("async_reset_counters", int'(sweep_cnt) + int'(flip_cnt), 0);
        exp_idx_q.delete();
        resp_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        #3;
        chk("reset_no_done", done_count - dc0, 0);
        chk("reset_idle_busy", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ising_sweep_ctrl.md
Name: ising_sweep_ctrl

Overview:
Sequencer for the matrix/coupling datapath of the Recurrent Ising Sampler.
- Owns the spin vector and runs a programmed number of sweeps.
- Each sweep requests a local-field computation for every spin index in turn, adds noise, and writes back the sign decision.
- Sits between the AXI4-Lite register slave (start, sweeps, abort, init) and the coupling-matrix MAC engine.

Parameters:
N_SPINS, 64, number of spins; power of two, 2..512
IDX_W, 6, spin index width, clog2(N_SPINS)
FIELD_W, 16, signed width of local field and noise
SWEEP_W, 16, sweep counter width

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle start pulse
cfg_sweeps  in  SWEEP_W  number of sweeps, sampled on accepted start
cfg_abort  in  1  abort pulse
spin_init_load  in  1  load spin_init into spin register
spin_init  in  N_SPINS  initial spin vector
row_req_valid  out  1  field request valid
row_req_ready  in  1  MAC engine accepts request
row_req_idx  out  IDX_W  spin index whose field is requested
fld_valid  in  1  field result valid
fld_data  in  FIELD_W  signed local field
fld_ready  out  1  controller accepts field
rnd_data  in  FIELD_W  signed noise sample
rnd_ack  out  1  noise sample consumed
spin_vec  out  N_SPINS  current spins (bit=1 means +1)
busy  out  1  run in progress
done  out  1  one-cycle completion pulse
sweep_cnt  out  SWEEP_W  completed sweeps in current/last run
flip_cnt  out  32  spin flips in current/last run, wraps at 2^32

Behaviour:
- Reset clock/polarity: one clock, s00_axi_aclk; reset s00_axi_aresetn is asynchronous, active-low.
- Reset values: all outputs 0; spin_vec=0; state IDLE.
- FSM states:
  - IDLE:
    - cfg_start with cfg_sweeps!=0 → ISSUE; idx=0, sweep_cnt=0, flip_cnt=0, latch cfg_sweeps.
    - cfg_start with cfg_sweeps==0 → DONE; counters cleared.
    - spin_init_load loads spin_vec. It is honoured only in IDLE. If it coincides with start, the load happens first, so the run uses the new spins.
  - ISSUE: row_req_valid=1, row_req_idx=idx. Valid and idx stay stable until row_req_ready. On handshake → WAIT.
  - WAIT: fld_ready=1. On fld_valid: sum = sext(fld_data)+sext(rnd_data) in FIELD_W+1 bits (no overflow); new spin = (sum>=0); register it → UPDATE.
  - UPDATE:
    - Write spin_vec[idx]; flip_cnt++ if the bit changed; rnd_ack=1 for exactly this cycle.
    - If idx==N_SPINS-1: idx=0, sweep_cnt++. If the incremented count equals the latched sweeps → DONE, else → ISSUE.
    - Otherwise idx++ → ISSUE.
  - DONE: done=1 for one cycle → IDLE.
- busy=1 in ISSUE, WAIT, UPDATE. busy=0 in IDLE and DONE.
- Throughput: minimum 3 cycles per spin (ready and valid both immediate). One sweep = 3*N_SPINS cycles minimum. Latency from start to done = 3*N_SPINS*sweeps + 1 cycles.
- cfg_start while not IDLE: ignored.
- fld_valid outside WAIT: ignored; fld_ready=0.
- cfg_abort:
  - In ISSUE/WAIT/UPDATE: next state IDLE. row_req_valid drops immediately; no done pulse.
  - spin_vec keeps any writes already done, including an UPDATE in the abort cycle. Counters hold.
  - The MAC engine must tolerate withdrawn requests.
- cfg_abort in IDLE/DONE: no effect; DONE still pulses.
- Sequential updates: spin_vec changes only in UPDATE, so the request for idx+1 sees the updated spin idx.
- Reset mid-run: immediate return to reset values.

Decomposition:
- Package ising_ctrl_pkg:
  - state enum {IDLE, ISSUE, WAIT, UPDATE, DONE}
  - default widths
  - function for the widened signed sum
- One sub-module, ising_spin_decide:
  - registered sign decision
  - flip detect (new vs old bit) feeding flip_cnt

Test Plan:
1. Reset mid-run: assert reset during WAIT → all outputs 0, spin_vec=0 asynchronously; no done pulse afterwards.
2. N_SPINS=4, spin_init=4'b0000, sweeps=1, fld_data=+5, rnd_data=0, ready/valid immediate → spin_vec=4'b1111, flip_cnt=4, sweep_cnt=1, done 13 cycles after start.
3. Boundary sum: fld_data=-3, rnd_data=+3 → spin=1. fld_data=-32768, rnd_data=-32768 → spin=0, no overflow. fld_data=32767, rnd_data=32767 → spin=1.
4. Backpressure: row_req_ready held low 5 cycles → row_req_valid and row_req_idx stable throughout. fld_valid delayed 7 cycles → exactly one rnd_ack per spin.
5. Sweeps=3 on N_SPINS=4 with alternating field sign per visit → row_req_idx sequence 0,1,2,3 repeated 3 times; sweep_cnt=3; flip_cnt matches the scoreboard.
6. Zero sweeps and abort:
   - Start with sweeps=0 → done one cycle after start, busy never 1.
   - Abort during WAIT of idx 2 → busy 0 next cycle, no done; spins 0..1 updated, spins 2..3 unchanged.
   - A subsequent start runs normally.
